// File: rtl/dma_arbiter_if.sv
// DMA link bundle: one requester-side and one controller-side view of the same signals.
// Pure wiring, no latency.
// No backpressure beyond the dma_ack / dev_ack handshake it carries.
interface dma_arbiter_if;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic        dma_ack;
    logic        dma_end_flag;
    logic        dma_error_flag;
    logic [15:0] dev_in;

    // master issues requests; slave answers them
    modport master (
        output dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
        input  dma_ack, dma_end_flag, dma_error_flag, dev_in
    );
    modport slave (
        input  dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
        output dma_ack, dma_end_flag, dma_error_flag, dev_in
    );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin share of one DMA controller port between two DMA devices.
// Latency: request to grant/dma_rqst 1 cycle; muxing while granted is combinational.
// Backpressure: losing device simply waits with its request high until the grant returns to IDLE.
module dma_arbiter #(
    parameter logic [15:0] WDOG_CYCLES = 16'd1024
) (
    input  logic          clk,
    input  logic          reset,
    dma_arbiter_if.slave  d0,
    dma_arbiter_if.slave  d1,
    dma_arbiter_if.master ctrl,
    output logic [1:0]    grant,
    output logic          arb_timeout,
    output logic [15:0]   word_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  grant_nxt;
    logic        last_d1;
    logic [15:0] wdog_cnt;
    logic        active;
    logic        sel0;
    logic        sel1;
    logic        flag_in;
    logic        abort;
    logic        wdog_hit;

    assign active  = (state == GRANT) && !reset;
    assign sel0    = active && grant[0];
    assign sel1    = active && grant[1];
    assign flag_in = ctrl.dma_end_flag || ctrl.dma_error_flag;
    assign abort   = grant[1] ? !d1.dma_rqst : !d0.dma_rqst;

    // Watchdog only fires when no higher-priority release reason is present.
    assign wdog_hit = active && (WDOG_CYCLES != 16'd0) && (wdog_cnt == WDOG_CYCLES - 16'd1)
                      && !ctrl.dma_ack && !flag_in && !abort;
    assign arb_timeout = wdog_hit;

    always_comb begin
        ctrl.dma_rqst          = 1'b0;
        ctrl.dma_rd_wr         = 1'b0;
        ctrl.dma_start_address = 16'd0;
        ctrl.dma_num_words     = 16'd0;
        ctrl.dev_ack           = 1'b0;
        ctrl.dev_out           = 16'd0;
        if (sel0) begin
            ctrl.dma_rqst          = d0.dma_rqst;
            ctrl.dma_rd_wr         = d0.dma_rd_wr;
            ctrl.dma_start_address = d0.dma_start_address;
            ctrl.dma_num_words     = d0.dma_num_words;
            ctrl.dev_ack           = d0.dev_ack;
            ctrl.dev_out           = d0.dev_out;
        end else if (sel1) begin
            ctrl.dma_rqst          = d1.dma_rqst;
            ctrl.dma_rd_wr         = d1.dma_rd_wr;
            ctrl.dma_start_address = d1.dma_start_address;
            ctrl.dma_num_words     = d1.dma_num_words;
            ctrl.dev_ack           = d1.dev_ack;
            ctrl.dev_out           = d1.dev_out;
        end
    end

    assign d0.dma_ack        = sel0 && ctrl.dma_ack;
    assign d0.dma_end_flag   = sel0 && ctrl.dma_end_flag;
    assign d0.dma_error_flag = sel0 && (ctrl.dma_error_flag || wdog_hit);
    assign d0.dev_in         = sel0 ? ctrl.dev_in : 16'd0;
    assign d1.dma_ack        = sel1 && ctrl.dma_ack;
    assign d1.dma_end_flag   = sel1 && ctrl.dma_end_flag;
    assign d1.dma_error_flag = sel1 && (ctrl.dma_error_flag || wdog_hit);
    assign d1.dev_in         = sel1 ? ctrl.dev_in : 16'd0;

    always_comb begin
        next_state = state;
        grant_nxt  = grant;
        case (state)
            IDLE: begin
                if (d0.dma_rqst && d1.dma_rqst) begin
                    next_state = GRANT;
                    grant_nxt  = last_d1 ? 2'b01 : 2'b10;
                end else if (d0.dma_rqst) begin
                    next_state = GRANT;
                    grant_nxt  = 2'b01;
                end else if (d1.dma_rqst) begin
                    next_state = GRANT;
                    grant_nxt  = 2'b10;
                end
            end
            GRANT: begin
                if (flag_in || abort || wdog_hit) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                next_state = IDLE;
                grant_nxt  = 2'b00;
            end
            default: begin
                next_state = IDLE;
                grant_nxt  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 2'b00;
            word_cnt <= 16'd0;
            wdog_cnt <= 16'd0;
            last_d1  <= 1'b1;
        end else begin
            state <= next_state;
            grant <= grant_nxt;
            if (state == IDLE && next_state == GRANT) begin
                word_cnt <= 16'd0;
                wdog_cnt <= 16'd0;
            end else if (state == GRANT) begin
                if (ctrl.dma_ack) begin
                    word_cnt <= word_cnt + 16'd1;
                    wdog_cnt <= 16'd0;
                end else if (wdog_cnt != 16'hFFFF) begin
                    wdog_cnt <= wdog_cnt + 16'd1;
                end
            end
            if (state == RELEASE) begin
                last_d1 <= grant[1];
            end
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level ownership model.
module tb_dma_arbiter;
    localparam logic [15:0] W = 16'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  grant;
    logic        arb_timeout;
    logic [15:0] word_cnt;
    int          total = 0;
    int          bad = 0;

    dma_arbiter_if d0_if ();
    dma_arbiter_if d1_if ();
    dma_arbiter_if c_if ();

    always #5 clk = ~clk;

    dma_arbiter #(.WDOG_CYCLES(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .d0         (d0_if),
        .d1         (d1_if),
        .ctrl       (c_if),
        .grant      (grant),
        .arb_timeout(arb_timeout),
        .word_cnt   (word_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the port, whether the owner is being released, and transfer stats.
    int m_owner = 0;   // 0 nobody, 1 device 0, 2 device 1
    bit m_rel   = 1'b0;
    int m_last  = 1;   // device released most recently
    int m_acks  = 0;
    int m_quiet = 0;   // cycles since the last ack in this grant

    function automatic bit owner_rqst();
        return (m_owner == 2) ? d1_if.dma_rqst : d0_if.dma_rqst;
    endfunction

    function automatic bit serving();
        return (m_owner != 0) && !m_rel && !reset;
    endfunction

    function automatic bit times_out();
        return serving() && (m_quiet == int'(W) - 1) && !c_if.dma_ack && !c_if.dma_end_flag
               && !c_if.dma_error_flag && owner_rqst();
    endfunction

    task automatic model_check();
        bit s0, s1, to;
        s0 = serving() && m_owner == 1;
        s1 = serving() && m_owner == 2;
        to = times_out();
        chk("grant", grant, (m_owner == 0) ? 0 : ((m_owner == 1) ? 1 : 2));
        chk("word_cnt", word_cnt, m_acks);
        chk("arb_timeout", arb_timeout, to);
        chk("c_rqst", c_if.dma_rqst, s0 ? d0_if.dma_rqst : (s1 ? d1_if.dma_rqst : 1'b0));
        chk("c_rd_wr", c_if.dma_rd_wr, s0 ? d0_if.dma_rd_wr : (s1 ? d1_if.dma_rd_wr : 1'b0));
        chk("c_addr", c_if.dma_start_address,
            s0 ? d0_if.dma_start_address : (s1 ? d1_if.dma_start_address : 16'd0));
        chk("c_num", c_if.dma_num_words,
            s0 ? d0_if.dma_num_words : (s1 ? d1_if.dma_num_words : 16'd0));
        chk("c_dev_ack", c_if.dev_ack, s0 ? d0_if.dev_ack : (s1 ? d1_if.dev_ack : 1'b0));
        chk("c_dev_out", c_if.dev_out, s0 ? d0_if.dev_out : (s1 ? d1_if.dev_out : 16'd0));
        chk("d0_ack", d0_if.dma_ack, s0 && c_if.dma_ack);
        chk("d1_ack", d1_if.dma_ack, s1 && c_if.dma_ack);
        chk("d0_end", d0_if.dma_end_flag, s0 && c_if.dma_end_flag);
        chk("d1_end", d1_if.dma_end_flag, s1 && c_if.dma_end_flag);
        chk("d0_err", d0_if.dma_error_flag, s0 && (c_if.dma_error_flag || to));
        chk("d1_err", d1_if.dma_error_flag, s1 && (c_if.dma_error_flag || to));
        chk("d0_dev_in", d0_if.dev_in, s0 ? c_if.dev_in : 16'd0);
        chk("d1_dev_in", d1_if.dev_in, s1 ? c_if.dev_in : 16'd0);
    endtask

    task automatic model_step();
        bit done;
        if (reset) begin
            m_owner = 0; m_rel = 1'b0; m_last = 1; m_acks = 0; m_quiet = 0;
        end else if (m_owner == 0) begin
            if (d0_if.dma_rqst && d1_if.dma_rqst) m_owner = (m_last == 0) ? 2 : 1;
            else if (d0_if.dma_rqst)              m_owner = 1;
            else if (d1_if.dma_rqst)              m_owner = 2;
            if (m_owner != 0) begin m_acks = 0; m_quiet = 0; end
        end else if (m_rel) begin
            m_last = m_owner - 1; m_owner = 0; m_rel = 1'b0;
        end else begin
            done = c_if.dma_end_flag || c_if.dma_error_flag || !owner_rqst() || times_out();
            if (c_if.dma_ack) begin
                m_acks = (m_acks + 1) % 65536; m_quiet = 0;
            end else if (m_quiet < 65535) begin
                m_quiet++;
            end
            if (done) m_rel = 1'b1;
        end
    endtask

    initial begin
        @(posedge clk);
        model_step();
        forever begin
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d0_if.dma_rqst = 0; d0_if.dma_rd_wr = 0; d0_if.dma_start_address = 0;
        d0_if.dma_num_words = 0; d0_if.dev_ack = 0; d0_if.dev_out = 0;
        d1_if.dma_rqst = 0; d1_if.dma_rd_wr = 0; d1_if.dma_start_address = 0;
        d1_if.dma_num_words = 0; d1_if.dev_ack = 0; d1_if.dev_out = 0;
        c_if.dma_ack = 0; c_if.dma_end_flag = 0; c_if.dma_error_flag = 0; c_if.dev_in = 0;
    endtask

    initial begin
        int gap;
        bit found;
        int ack_pct;
        clear_inputs();
        reset = 1;
        repeat (2) cyc();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_word_cnt", word_cnt, 16'd0);
        chk("rst_c_rqst", c_if.dma_rqst, 1'b0);
        chk("rst_timeout", arb_timeout, 1'b0);
        cyc();
        reset = 0;

        // single requester
        d0_if.dma_rqst = 1; d0_if.dma_start_address = 16'h0200; d0_if.dma_num_words = 16'd4;
        #1;
        chk("t1_idle_grant", grant, 2'b00);
        chk("t1_idle_rqst", c_if.dma_rqst, 1'b0);
        cyc();
        c_if.dma_ack = 1;
        #1;
        chk("t1_grant", grant, 2'b01);
        chk("t1_addr", c_if.dma_start_address, 16'h0200);
        chk("t1_num", c_if.dma_num_words, 16'd4);
        chk("t1_rqst", c_if.dma_rqst, 1'b1);
        chk("t1_d0_ack", d0_if.dma_ack, 1'b1);
        repeat (3) cyc();
        cyc();
        c_if.dma_ack = 0; c_if.dma_end_flag = 1;
        #1;
        chk("t1_word_cnt", word_cnt, 16'd4);
        chk("t1_d0_end", d0_if.dma_end_flag, 1'b1);
        chk("t1_d1_end", d1_if.dma_end_flag, 1'b0);
        cyc();
        c_if.dma_end_flag = 0; d0_if.dma_rqst = 0;
        #1;
        chk("t1_rel_rqst", c_if.dma_rqst, 1'b0);
        chk("t1_rel_grant", grant, 2'b01);
        cyc();
        #1;
        chk("t1_idle_after", grant, 2'b00);

        // contention from reset
        cyc(); reset = 1;
        cyc(); reset = 0;
        d0_if.dma_rqst = 1; d1_if.dma_rqst = 1;
        d0_if.dma_start_address = 16'h1000; d1_if.dma_start_address = 16'h2000;
        cyc();
        #1;
        chk("t2_first_d0", grant, 2'b01);
        cyc();
        c_if.dma_end_flag = 1;
        cyc();
        c_if.dma_end_flag = 0;
        gap = 0; found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            #1;
            if (c_if.dma_rqst) found = 1;
            else begin gap++; cyc(); end
        end
        chk("t2_found", found, 1'b1);
        chk("t2_gap", gap, 2);
        chk("t2_then_d1", grant, 2'b10);
        chk("t2_addr_d1", c_if.dma_start_address, 16'h2000);

        // isolation, then abort after two acks
        cyc();
        c_if.dma_ack = 1; c_if.dev_in = 16'hBEEF;
        #1;
        chk("t3_d1_dev_in", d1_if.dev_in, 16'hBEEF);
        chk("t3_d0_dev_in", d0_if.dev_in, 16'h0000);
        chk("t3_d0_ack", d0_if.dma_ack, 1'b0);
        chk("t3_d1_ack", d1_if.dma_ack, 1'b1);
        cyc();
        cyc();
        c_if.dma_ack = 0; c_if.dev_in = 0; d1_if.dma_rqst = 0;
        #1;
        chk("t3_wc_abort", word_cnt, 16'd2);
        cyc();
        #1;
        chk("t3_wc_rel", word_cnt, 16'd2);
        chk("t3_rel_rqst", c_if.dma_rqst, 1'b0);
        cyc();
        #1;
        chk("t3_idle_grant", grant, 2'b00);
        cyc();
        #1;
        chk("t3_d0_next", grant, 2'b01);
        chk("t3_wc_clear", word_cnt, 16'd0);

        // watchdog: d0 holds the port with no acks
        repeat (6) cyc();
        #1;
        chk("t4_no_to_yet", arb_timeout, 1'b0);
        cyc();
        #1;
        chk("t4_timeout", arb_timeout, 1'b1);
        chk("t4_d0_err", d0_if.dma_error_flag, 1'b1);
        chk("t4_d1_err", d1_if.dma_error_flag, 1'b0);
        cyc();
        d0_if.dma_rqst = 0;
        #1;
        chk("t4_pulse_end", arb_timeout, 1'b0);
        chk("t4_rel_grant", grant, 2'b01);
        cyc();
        #1;
        chk("t4_grant_off", grant, 2'b00);

        // reset in the middle of a transfer
        cyc();
        d1_if.dma_rqst = 1;
        cyc();
        c_if.dma_ack = 1;
        cyc();
        cyc();
        c_if.dma_ack = 0; reset = 1;
        cyc();
        reset = 0; d0_if.dma_rqst = 1;
        #1;
        chk("t5_grant", grant, 2'b00);
        chk("t5_rqst", c_if.dma_rqst, 1'b0);
        chk("t5_wc", word_cnt, 16'd0);
        cyc();
        #1;
        chk("t5_d0_tie", grant, 2'b01);

        // random traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            cyc();
            ack_pct = ((i / 200) % 2 == 0) ? 50 : 8;
            reset = ($urandom_range(299) == 0);
            if (d0_if.dma_rqst) d0_if.dma_rqst = ($urandom_range(15) != 0);
            else                d0_if.dma_rqst = ($urandom_range(3) == 0);
            if (d1_if.dma_rqst) d1_if.dma_rqst = ($urandom_range(15) != 0);
            else                d1_if.dma_rqst = ($urandom_range(3) == 0);
            d0_if.dma_rd_wr = 1'($urandom); d1_if.dma_rd_wr = 1'($urandom);
            d0_if.dma_start_address = 16'($urandom); d1_if.dma_start_address = 16'($urandom);
            d0_if.dma_num_words = 16'($urandom); d1_if.dma_num_words = 16'($urandom);
            d0_if.dev_ack = 1'($urandom); d1_if.dev_ack = 1'($urandom);
            d0_if.dev_out = 16'($urandom); d1_if.dev_out = 16'($urandom);
            c_if.dma_ack = ($urandom_range(99) < ack_pct);
            c_if.dma_end_flag = ($urandom_range(19) == 0);
            c_if.dma_error_flag = ($urandom_range(39) == 0);
            c_if.dev_in = 16'($urandom);
        end
        cyc();
        clear_inputs();
        reset = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
